rgb_gray_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed-size RGB-to-gray converter.
- Accepts one RGB pixel per cycle over a valid/ready stream and emits one gray pixel per accepted input.
- Selectable conversion mode; counts pixels per frame, flags the last output and pulses done at frame end.
- Sits between the planar pixel fetch (frame memory reader) and the gray-image writer.

---
 rtl/rgb_gray_pipe.sv | 193 +++++++++++++++++++
 tb/tb_rgb_gray_pipe.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_gray_pipe.sv
// -----------------------------------------------------------------------------
// rgb_gray_pipe
//
// Streaming RGB-to-gray converter. It accepts one RGB pixel per cycle on a
// valid/ready input and produces one gray pixel per accepted input through a
// two-stage pipeline. It counts pixels per frame, flags the last output pixel
// and pulses done when the frame's final output has been handed off.
//
// Optional build macro: GRAY_ROUND_EN
//   defined   : modes 00/01 add 128 before the >>8 (round half up)
//   undefined : modes 00/01 truncate
//   Modes 10/11 are identical in both builds.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      one-cycle pulse that begins a frame (honoured only in IDLE)
//   mode[1:0]  00 luma, 01 average, 10 green, 11 max(R,G,B); latched on start
//   in_valid   input pixel valid
//   in_ready   block can accept a pixel this cycle
//   in_r/g/b   colour channels, DW bits each
//   out_valid  out_gray valid
//   out_ready  downstream accepts out_gray
//   out_gray   converted pixel, DW bits
//   out_last   high with the frame's final output pixel
//   busy       high while streaming a frame
//   done       one-cycle pulse after the final output handshake
//   pix_cnt    output pixels delivered in the current or last frame
// -----------------------------------------------------------------------------
module rgb_gray_pipe #(
    parameter int DW   = 8,
    parameter int ROWS = 1153,
    parameter int COLS = 2048,
    parameter int CW   = 22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_r,
    input  logic [DW-1:0] in_g,
    input  logic [DW-1:0] in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_gray,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pix_cnt
);

    localparam int PW = DW + 8;    // per-channel product width
    localparam int SW = DW + 10;   // weighted-sum width
    localparam logic [CW-1:0] N_PIX = CW'(ROWS * COLS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] in_cnt;
    logic [1:0]    mode_q;

    // Stage 1: per-channel products
    logic          v1;
    logic          last1;
    logic [PW-1:0] p_r, p_g, p_b;

    // Stage 2: weighted sum and last flag
    logic          v2;
    logic          last2;
    logic [SW-1:0] sum_q;

    logic          en;
    logic          accept;
    logic          out_hs;
    logic [DW-1:0] mx;
    logic [PW-1:0] p_r_d, p_g_d, p_b_d;
    logic [SW-1:0] round_add;
    logic [SW-1:0] sum_d;

    // Whole pipeline advances together; it only freezes while an output is
    // being offered and not taken.
    assign en     = !out_valid || out_ready;
    assign in_ready = (state == RUN) && en && (in_cnt < N_PIX);
    assign accept = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    // Modes 10/11 are expressed as a single "product" of value*256 so every
    // mode shares the same sum and >>8 path and therefore the same latency.
    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        mx    = in_r;
        p_r_d = '0;
        p_g_d = '0;
        p_b_d = '0;
        if (in_g > mx) mx = in_g;
        if (in_b > mx) mx = in_b;
        unique case (mode_q)
            2'b00: begin
                p_r_d = PW'(in_r) * PW'(77);
                p_g_d = PW'(in_g) * PW'(150);
                p_b_d = PW'(in_b) * PW'(29);
            end
            2'b01: begin
                p_r_d = PW'(in_r) * PW'(85);
                p_g_d = PW'(in_g) * PW'(85);
                p_b_d = PW'(in_b) * PW'(86);
            end
            2'b10:   p_g_d = PW'(in_g) << 8;
            default: p_r_d = PW'(mx) << 8;
        endcase
    end

    // mode_q cannot change while pixels are in flight (a frame only ends once
    // the pipeline has drained), so it is safe to use it in stage 2 as well.
`ifdef GRAY_ROUND_EN
    assign round_add = mode_q[1] ? '0 : SW'(128);
`else
    assign round_add = '0;
`endif

    assign sum_d = SW'(p_r) + SW'(p_g) + SW'(p_b) + round_add;

    // The weights sum to 256, so sum>>8 never exceeds 2^DW-1; the bits above
    // and below the result window are simply dropped.
    assign out_gray  = sum_q[DW+7:8];
    assign out_valid = v2;
    assign out_last  = last2;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    logic unused_sum_bits;
    assign unused_sum_bits = ^{sum_q[SW-1:DW+8], sum_q[7:0]};

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            in_cnt <= '0;
            pix_cnt <= '0;
            mode_q <= 2'b00;
            v1     <= 1'b0;
            v2     <= 1'b0;
            last1  <= 1'b0;
            last2  <= 1'b0;
            // NOTE: the data registers are only a few flops, so they are
            // reset too; that keeps out_gray at 0 out of reset.
            p_r    <= '0;
            p_g    <= '0;
            p_b    <= '0;
            sum_q  <= '0;
        end else begin
            if (en) begin
                v1    <= accept;
                last1 <= accept && (in_cnt == N_PIX - CW'(1));
                if (accept) begin
                    p_r <= p_r_d;
                    p_g <= p_g_d;
                    p_b <= p_b_d;
                end
                v2    <= v1;
                last2 <= v1 && last1;
                if (v1) sum_q <= sum_d;
            end

            if (accept) in_cnt  <= in_cnt + CW'(1);
            if (out_hs) pix_cnt <= pix_cnt + CW'(1);

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        in_cnt  <= '0;
                        pix_cnt <= '0;
                        mode_q  <= mode;
                    end
                end
                RUN: begin
                    if (out_hs && out_last) state <= DONE;
                end
                default: state <= IDLE;   // DONE lasts exactly one cycle
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_gray_pipe.sv
// -----------------------------------------------------------------------------
// tb_rgb_gray_pipe
//
// Self-checking bench for rgb_gray_pipe with a 2x3 frame. The driver pushes
// the hand-computed gray value (and last flag) of every accepted pixel into a
// queue; an independent monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_rgb_gray_pipe;

    localparam int DW   = 8;
    localparam int ROWS = 2;
    localparam int COLS = 3;
    localparam int CW   = 4;
    localparam int NPIX = ROWS * COLS;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_r, in_g, in_b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_gray;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [CW-1:0] pix_cnt;

    rgb_gray_pipe #(.DW(DW), .ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gray  (out_gray),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .pix_cnt   (pix_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int gray;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_errors = 0;
    int frame_outs = 0;
    int frame_idx  = 0;
    int cur_mode   = 0;

    // Directed pixels and their hand-computed results per mode.
    int pr [6] = '{100, 255, 0, 10, 200, 1};
    int pg [6] = '{150, 255, 0, 20,  50, 2};
    int pb [6] = '{200, 255, 0, 30, 100, 3};
    int exp_tab [4][6];

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every output handshake pops one expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_gray", int'(out_gray), mon_e.gray);
                check("out_last", int'(out_last), int'(mon_e.last));
            end
            frame_outs++;
        end
    end

    // Called right after a rising edge.
    task automatic start_frame(input int m);
        start = 1'b1;
        mode  = 2'(m);
        @(posedge clk); #1;
        start = 1'b0;
        mode  = ~2'(m);          // later changes on mode must not matter
        cur_mode   = m;
        frame_idx  = 0;
        frame_outs = 0;
        @(negedge clk);
        check("busy_after_start", int'(busy), 1);
        check("pix_cnt_cleared", int'(pix_cnt), 0);
        @(posedge clk); #1;
    endtask

    // Offer pixel idx until accepted; returns just after the accepting edge.
    task automatic send(input int idx);
        bit ok;
        ok = 1'b0;
        in_r = DW'(pr[idx]);
        in_g = DW'(pg[idx]);
        in_b = DW'(pb[idx]);
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                frame_idx++;
                exp_q.push_back('{gray: exp_tab[cur_mode][idx], last: (frame_idx == NPIX)});
                ok = 1'b1;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait for the last handshake, then check the done pulse and counters.
    task automatic finish_frame(input bit start_in_done);
        bit found;
        found = 1'b0;
        in_r = 8'd7; in_g = 8'd7; in_b = 8'd7;
        in_valid = 1'b1;          // surplus pixel that must never be taken
        @(negedge clk);
        check("in_ready_after_last_accept", int'(in_ready), 0);
        for (int t = 0; t < 50 && !found; t++) begin
            if (out_valid && out_ready && out_last) found = 1'b1;
            else @(negedge clk);
        end
        check("last_handshake_seen", int'(found), 1);
        @(negedge clk);
        check("done_pulse", int'(done), 1);
        check("busy_in_done", int'(busy), 0);
        check("out_valid_in_done", int'(out_valid), 0);
        check("pix_cnt_at_done", int'(pix_cnt), NPIX);
        if (start_in_done) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("idle_after_done", int'(busy), 0);
        check("pix_cnt_holds", int'(pix_cnt), NPIX);
        check("frame_output_count", frame_outs, NPIX);
        check("scoreboard_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int held;
        bit seen;

`ifdef GRAY_ROUND_EN
        exp_tab[0] = '{141, 255, 0, 18, 101, 2};
        exp_tab[1] = '{150, 255, 0, 20, 117, 2};
`else
        exp_tab[0] = '{140, 255, 0, 18, 100, 1};
        exp_tab[1] = '{150, 255, 0, 20, 116, 2};
`endif
        exp_tab[2] = '{150, 255, 0, 20,  50, 2};
        exp_tab[3] = '{200, 255, 0, 30, 200, 3};

        rst = 1'b1; start = 1'b0; mode = 2'b00; in_valid = 1'b0;
        in_r = '0; in_g = '0; in_b = '0; out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_gray", int'(out_gray), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pix_cnt", int'(pix_cnt), 0);
        check("rst_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Frame A: luma, latency of the first pixel, then a full frame
        start_frame(0);
        send(0);
        @(negedge clk);
        check("latency_cycle1_out_valid", int'(out_valid), 0);
        @(negedge clk);
        check("latency_cycle2_out_valid", int'(out_valid), 1);
        @(posedge clk); #1;
        for (int i = 1; i < NPIX; i++) send(i);
        finish_frame(1'b1);       // also pulses start during DONE

        // Frame B: average with a 3-cycle backpressure window
        start_frame(1);
        fork
            begin
                for (int i = 0; i < NPIX; i++) send(i);
            end
            begin
                seen = 1'b0;
                for (int t = 0; t < 50 && !seen; t++) begin
                    @(negedge clk);
                    if (frame_outs >= 1) seen = 1'b1;
                end
                check("bp_first_output_seen", int'(seen), 1);
                @(posedge clk); #1;
                out_ready = 1'b0;
                held = -1;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    if (c == 0) held = int'(out_gray);
                    else check("bp_out_gray_stable", int'(out_gray), held);
                    check("bp_out_valid_held", int'(out_valid), 1);
                    check("bp_in_ready_low", int'(in_ready), 0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        finish_frame(1'b0);

        // Frame C: max, with start and a mode change mid-frame
        start_frame(3);
        for (int i = 0; i < 3; i++) send(i);
        start = 1'b1;
        mode  = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("mid_start_still_busy", int'(busy), 1);
        @(posedge clk); #1;
        for (int i = 3; i < NPIX; i++) send(i);
        finish_frame(1'b0);

        // Frame D: green passthrough
        start_frame(2);
        for (int i = 0; i < NPIX; i++) send(i);
        finish_frame(1'b0);

        // Frame E: reset after three outputs
        start_frame(0);
        for (int i = 0; i < 5; i++) send(i);
        check("outputs_before_reset", frame_outs, 3);
        rst = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_gray", int'(out_gray), 0);
        check("midrst_out_last", int'(out_last), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_pix_cnt", int'(pix_cnt), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("no_done_after_reset", int'(done), 0);
            check("idle_after_reset", int'(busy), 0);
        end
        @(posedge clk); #1;

        // Frame F: full luma frame after the abandoned one
        start_frame(0);
        for (int i = 0; i < NPIX; i++) send(i);
        finish_frame(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
